// File: rtl/wb_regfile_pkg.sv
// Shared types, constants and read-select helper for the write-back
// register file slice.
package wb_regfile_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREGS  = 32;

   typedef logic [DATA_W-1:0] reg_bus_t;
   typedef logic [ADDR_W-1:0] reg_addr_t;

   localparam reg_bus_t  ZeroWord     = '0;
   localparam reg_addr_t NOPRegAddr   = '0;
   localparam logic      WriteEnable  = 1'b1;
   localparam logic      WriteDisable = 1'b0;
   localparam logic      ReadEnable   = 1'b1;

   typedef struct packed {
      logic      wreg;
      reg_addr_t wd;
      reg_bus_t  wdata;
   } wb_entry_t;

   // Ordered read select: reset, disable, r0, same-cycle bypass, array.
   function automatic reg_bus_t rd_sel(
      input logic      rst,
      input logic      re,
      input reg_addr_t raddr,
      input logic      we,
      input reg_addr_t waddr,
      input reg_bus_t  wdata,
      input reg_bus_t  arr
   );
      if (rst)
         return ZeroWord;
      else if (re != ReadEnable)
         return ZeroWord;
      else if (raddr == NOPRegAddr)
         return ZeroWord;
      else if (we == WriteEnable && raddr == waddr)
         return wdata;
      else
         return arr;
   endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB and decode read signals of the write-back register file.
// master = pipeline side, slave = register file.
interface wb_regfile_if;
   import wb_regfile_pkg::*;

   logic      stall;
   logic      mem_wreg_i;
   reg_addr_t mem_wd_i;
   reg_bus_t  mem_wdata_i;
   logic      re1;
   logic      re2;
   reg_addr_t raddr1;
   reg_addr_t raddr2;
   reg_bus_t  rdata1;
   reg_bus_t  rdata2;
   logic      wb_wreg_o;
   reg_addr_t wb_wd_o;
   reg_bus_t  wb_wdata_o;

   modport master (
      output stall, mem_wreg_i, mem_wd_i, mem_wdata_i,
      output re1, re2, raddr1, raddr2,
      input  rdata1, rdata2,
      input  wb_wreg_o, wb_wd_o, wb_wdata_o
   );

   modport slave (
      input  stall, mem_wreg_i, mem_wd_i, mem_wdata_i,
      input  re1, re2, raddr1, raddr2,
      output rdata1, rdata2,
      output wb_wreg_o, wb_wd_o, wb_wdata_o
   );

endinterface

// File: rtl/wb_regfile_core.sv
// 32x32 register array with one write port and two bypassed
// combinational read ports; r0 is never written.
module wb_regfile_core
   import wb_regfile_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      i_we,
   input  reg_addr_t i_waddr,
   input  reg_bus_t  i_wdata,
   input  logic      i_re1,
   input  reg_addr_t i_raddr1,
   input  logic      i_re2,
   input  reg_addr_t i_raddr2,
   output reg_bus_t  o_rdata1,
   output reg_bus_t  o_rdata2
);

   reg_bus_t r_regs [NREGS];
   logic     w_commit;

   assign w_commit = (i_we == WriteEnable) &&
                     (i_waddr != NOPRegAddr);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++)
            r_regs[i] <= ZeroWord;
      end else if (w_commit) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   always_comb begin
      o_rdata1 = rd_sel(rst, i_re1, i_raddr1,
                        i_we, i_waddr, i_wdata,
                        r_regs[i_raddr1]);
      o_rdata2 = rd_sel(rst, i_re2, i_raddr2,
                        i_we, i_waddr, i_wdata,
                        r_regs[i_raddr2]);
   end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: MEM/WB pipeline register with stall hold,
// feeding the bypassed register file core.
module wb_regfile
   import wb_regfile_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   wb_regfile_if.slave bus
);

   wb_entry_t r_wb;

   // A stalled entry stays put and is recommitted each cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wb <= '{wreg:  WriteDisable,
                   wd:    NOPRegAddr,
                   wdata: ZeroWord};
      end else if (!bus.stall) begin
         r_wb <= '{wreg:  bus.mem_wreg_i,
                   wd:    bus.mem_wd_i,
                   wdata: bus.mem_wdata_i};
      end
   end

   assign bus.wb_wreg_o  = r_wb.wreg;
   assign bus.wb_wd_o    = r_wb.wd;
   assign bus.wb_wdata_o = r_wb.wdata;

   wb_regfile_core u_core (
      .clk      (clk),
      .rst      (rst),
      .i_we     (r_wb.wreg),
      .i_waddr  (r_wb.wd),
      .i_wdata  (r_wb.wdata),
      .i_re1    (bus.re1),
      .i_raddr1 (bus.raddr1),
      .i_re2    (bus.re2),
      .i_raddr2 (bus.raddr2),
      .o_rdata1 (bus.rdata1),
      .o_rdata2 (bus.rdata2)
   );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: vector table, hand sequences,
// and randomized traffic against a behavioural model.
module tb_wb_regfile;
   import wb_regfile_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   wb_regfile_if bus ();

   wb_regfile dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: architectural registers plus the pending WB slot.
   logic [31:0] m_regs [32];
   logic        m_wreg;
   logic [4:0]  m_wd;
   logic [31:0] m_wdata;

   function automatic logic [31:0] m_read(input logic re,
                                          input logic [4:0] a);
      if (rst || !re || a == 5'd0) return 32'd0;
      if (m_wreg && a == m_wd) return m_wdata;
      return m_regs[a];
   endfunction

   task automatic m_step();
      if (rst) begin
         foreach (m_regs[i]) m_regs[i] = 32'd0;
         m_wreg = 1'b0; m_wd = 5'd0; m_wdata = 32'd0;
      end else begin
         if (m_wreg && m_wd != 5'd0) m_regs[m_wd] = m_wdata;
         if (!bus.stall) begin
            m_wreg  = bus.mem_wreg_i;
            m_wd    = bus.mem_wd_i;
            m_wdata = bus.mem_wdata_i;
         end
      end
   endtask

   task automatic tick();
      m_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic wr,
                        input logic [4:0] wd, input logic [31:0] wdat,
                        input logic r1, input logic [4:0] a1,
                        input logic r2, input logic [4:0] a2);
      bus.stall = st;
      bus.mem_wreg_i = wr;
      bus.mem_wd_i = wd;
      bus.mem_wdata_i = wdat;
      bus.re1 = r1; bus.raddr1 = a1;
      bus.re2 = r2; bus.raddr2 = a2;
   endtask

   typedef struct packed {
      logic        st;
      logic        wr;
      logic [4:0]  wd;
      logic [31:0] wdat;
      logic        r1;
      logic [4:0]  a1;
      logic        r2;
      logic [4:0]  a2;
      logic [31:0] e_rd1;
      logic [31:0] e_rd2;
      logic        e_wr;
      logic [4:0]  e_wd;
      logic [31:0] e_wdat;
   } vec_t;

   vec_t vecs [15];

   function automatic vec_t mk(
      input logic st, input logic wr, input logic [4:0] wd,
      input logic [31:0] wdat,
      input logic r1, input logic [4:0] a1,
      input logic r2, input logic [4:0] a2,
      input logic [31:0] e1, input logic [31:0] e2,
      input logic ew, input logic [4:0] ewd, input logic [31:0] edat);
      vec_t v;
      v.st = st; v.wr = wr; v.wd = wd; v.wdat = wdat;
      v.r1 = r1; v.a1 = a1; v.r2 = r2; v.a2 = a2;
      v.e_rd1 = e1; v.e_rd2 = e2;
      v.e_wr = ew; v.e_wd = ewd; v.e_wdat = edat;
      return v;
   endfunction

   initial begin
      n_checks = 0;
      n_fail = 0;
      // e_rd*: read before the edge; e_w*: WB register after the edge.
      vecs[0]  = mk(0,1,5,32'h1234_5678, 1,5, 0,0,
                    0, 0, 1,5,32'h1234_5678);
      vecs[1]  = mk(0,0,0,0, 1,5, 1,5,
                    32'h1234_5678, 32'h1234_5678, 0,0,0);
      vecs[2]  = mk(0,0,0,0, 1,5, 1,0,
                    32'h1234_5678, 0, 0,0,0);
      vecs[3]  = mk(0,1,0,32'hFFFF_FFFF, 1,0, 1,5,
                    0, 32'h1234_5678, 1,0,32'hFFFF_FFFF);
      vecs[4]  = mk(0,0,0,0, 1,0, 1,0, 0,0, 0,0,0);
      vecs[5]  = mk(0,0,0,0, 1,0, 1,0, 0,0, 0,0,0);
      vecs[6]  = mk(0,1,7,32'hA5A5_A5A5, 1,7, 0,0,
                    0, 0, 1,7,32'hA5A5_A5A5);
      vecs[7]  = mk(1,1,7,1, 1,7, 0,0,
                    32'hA5A5_A5A5, 0, 1,7,32'hA5A5_A5A5);
      vecs[8]  = mk(1,1,7,1, 1,7, 0,0,
                    32'hA5A5_A5A5, 0, 1,7,32'hA5A5_A5A5);
      vecs[9]  = mk(1,1,7,1, 1,7, 0,0,
                    32'hA5A5_A5A5, 0, 1,7,32'hA5A5_A5A5);
      vecs[10] = mk(0,1,7,1, 1,7, 0,0,
                    32'hA5A5_A5A5, 0, 1,7,1);
      vecs[11] = mk(0,0,0,0, 1,7, 1,7, 1,1, 0,0,0);
      vecs[12] = mk(0,1,7,32'hFF, 1,7, 1,7,
                    1, 1, 1,7,32'hFF);
      vecs[13] = mk(0,0,0,0, 1,7, 1,7,
                    32'hFF, 32'hFF, 0,0,0);
      vecs[14] = mk(0,0,0,0, 1,7, 0,7,
                    32'hFF, 0, 0,0,0);

      // Reset held 3 cycles, then every register reads zero.
      rst = 1'b1;
      drive(0,0,0,0, 0,0, 0,0);
      repeat (3) tick();
      check("rst wb_wreg", 32'(bus.wb_wreg_o), 0);
      check("rst wb_wd", 32'(bus.wb_wd_o), 0);
      check("rst wb_wdata", bus.wb_wdata_o, 0);
      rst = 1'b0;
      for (int a = 1; a < 32; a++) begin
         drive(0,0,0,0, 1,5'(a), 1,5'(a));
         #1;
         check($sformatf("rst r%0d p1", a), bus.rdata1, 0);
         check($sformatf("rst r%0d p2", a), bus.rdata2, 0);
      end
      drive(0,0,0,0, 0,0, 0,0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].st, vecs[i].wr, vecs[i].wd, vecs[i].wdat,
               vecs[i].r1, vecs[i].a1, vecs[i].r2, vecs[i].a2);
         #1;
         check($sformatf("v%0d rdata1", i), bus.rdata1, vecs[i].e_rd1);
         check($sformatf("v%0d rdata2", i), bus.rdata2, vecs[i].e_rd2);
         tick();
         check($sformatf("v%0d wb_wreg", i),
               32'(bus.wb_wreg_o), 32'(vecs[i].e_wr));
         check($sformatf("v%0d wb_wd", i),
               32'(bus.wb_wd_o), 32'(vecs[i].e_wd));
         check($sformatf("v%0d wb_wdata", i),
               bus.wb_wdata_o, vecs[i].e_wdat);
      end

      // Reset pulse with a pending write to r9: the entry is discarded.
      drive(0,1,9,32'hDEAD_BEEF, 1,9, 0,0);
      #1;
      tick();
      check("r9 wb_wreg", 32'(bus.wb_wreg_o), 1);
      check("r9 wb_wd", 32'(bus.wb_wd_o), 9);
      check("r9 bypass", bus.rdata1, 32'hDEAD_BEEF);
      rst = 1'b1;
      drive(0,0,0,0, 1,9, 1,9);
      #1;
      check("rst rdata1", bus.rdata1, 0);
      check("rst rdata2", bus.rdata2, 0);
      tick();
      rst = 1'b0;
      #1;
      check("post rst wb_wreg", 32'(bus.wb_wreg_o), 0);
      check("post rst r9", bus.rdata1, 0);
      tick();
      check("post rst r9 later", bus.rdata1, 0);

      // Randomized traffic; small address range forces hazards.
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 39) == 0);
         drive(($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)),
               $urandom(),
               ($urandom_range(0, 4) != 0),
               5'($urandom_range(0, 7)),
               ($urandom_range(0, 4) != 0),
               5'($urandom_range(0, 7)));
         #1;
         check("rand rdata1", bus.rdata1,
               m_read(bus.re1, bus.raddr1));
         check("rand rdata2", bus.rdata2,
               m_read(bus.re2, bus.raddr2));
         tick();
         check("rand wb_wreg", 32'(bus.wb_wreg_o), 32'(m_wreg));
         check("rand wb_wd", 32'(bus.wb_wd_o), 32'(m_wd));
         check("rand wb_wdata", bus.wb_wdata_o, m_wdata);
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
